// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and load/store. At most
//   one request is accepted per cycle. The winner is registered onto the
//   memory port, and read data returns to its owner two cycles after the
//   grant. Data requests have priority over fetch.
//
//   Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//     defined   : a starvation counter forces a fetch grant after STARVE_MAX
//                 consecutive refused fetch cycles.
//     undefined : strict data priority; STARVE_MAX is not used.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     if_req/if_addr             fetch request (word read) and byte address
//     if_gnt                     fetch accepted this cycle (combinational)
//     if_rvalid/if_rdata         fetch read return
//     flush                      kill all fetch reads not yet returned
//     d_req/d_we/d_funct3        data request, 1 = store, size/sign code
//     d_addr/d_wdata             data byte address, store data
//     d_gnt                      data accepted this cycle (combinational)
//     d_rvalid/d_rdata           load read return
//     read_address/read_data     memory read port (read_data lags one cycle)
//     write_mem/write_address/
//     write_data/funct3          registered memory write port and access code
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] read_address,
    input  logic [31:0] read_data,
    output logic        write_mem,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic [2:0]  funct3
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam logic [2:0] F3_WORD = 3'b010;

    logic [31:0] raddr_q, raddr_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        wmem_q, wmem_d;
    tag_t        tag1_q, tag1_d;
    tag_t        tag2_q, tag2_d;
    logic        if_gnt_w, d_gnt_w;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       force_fetch;

    always_comb begin
        force_fetch = (starve_q == SMAX) && if_req;
        if (force_fetch) begin
            // A flush vetoes the forced fetch; data may then use the port.
            if_gnt_w = !flush;
            d_gnt_w  = flush && d_req;
        end else begin
            d_gnt_w  = d_req;
            if_gnt_w = if_req && !d_req && !flush;
        end

        if (!if_req || if_gnt_w) begin
            starve_d = '0;
        end else if (starve_q != SMAX) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        d_gnt_w  = d_req;
        if_gnt_w = if_req && !d_req && !flush;
    end
`endif

    always_comb begin
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        wmem_d  = 1'b0;
        tag1_d  = '{valid: 1'b0, owner: OWN_FETCH};

        if (if_gnt_w) begin
            raddr_d = if_addr;
            f3_d    = F3_WORD;
            tag1_d  = '{valid: 1'b1, owner: OWN_FETCH};
        end else if (d_gnt_w) begin
            f3_d = d_funct3;
            if (d_we) begin
                waddr_d = d_addr;
                wdata_d = d_wdata;
                wmem_d  = 1'b1;
            end else begin
                raddr_d = d_addr;
                tag1_d  = '{valid: 1'b1, owner: OWN_DATA};
            end
        end

        // Flush drops fetch-owned tags in both stages; data tags survive.
        if (flush && tag1_d.owner == OWN_FETCH) begin
            tag1_d.valid = 1'b0;
        end
        tag2_d = tag1_q;
        if (flush && tag2_d.owner == OWN_FETCH) begin
            tag2_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            f3_q    <= F3_WORD;
            wmem_q  <= 1'b0;
            tag1_q  <= '{valid: 1'b0, owner: OWN_FETCH};
            tag2_q  <= '{valid: 1'b0, owner: OWN_FETCH};
        end else begin
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            wmem_q  <= wmem_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
        end
    end

    assign if_gnt        = if_gnt_w;
    assign d_gnt         = d_gnt_w;
    assign read_address  = raddr_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign funct3        = f3_q;
    assign write_mem     = wmem_q;

    assign if_rvalid = tag2_q.valid && (tag2_q.owner == OWN_FETCH) && !flush;
    assign d_rvalid  = tag2_q.valid && (tag2_q.owner == OWN_DATA);
    assign if_rdata  = read_data;
    assign d_rdata   = read_data;

endmodule
